// File: rtl/mda_adc_pkg.sv
// Shared types and constants for the LTC2308-style ADC sequencer.
// Holds the FSM state enum, channel/result widths, LTC2308 config-bit
// constants and the helper that builds the 6-bit config word.
package mda_adc_pkg;

  localparam int NUM_CH         = 8;
  localparam int CH_W           = 3;
  localparam int RESULT_W       = 12;
  localparam int CFG_W          = 6;
  localparam int CONVST_CYCLES  = 2;

  // LTC2308 config bits: single-ended, unipolar, awake.
  localparam logic CFG_SD  = 1'b1;
  localparam logic CFG_UNI = 1'b1;
  localparam logic CFG_SLP = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVST,
    S_CONV,
    S_SHIFT,
    S_DONE,
    S_ACQ
  } state_e;

  // Config word sent MSB first: {S/D, O/S, S1, S0, UNI, SLP}.
  function automatic logic [CFG_W-1:0] cfg_word(input logic [CH_W-1:0] ch);
    return {CFG_SD, ch[0], ch[2], ch[1], CFG_UNI, CFG_SLP};
  endfunction

endpackage

// File: rtl/mda_adc_shifter.sv
// SCK generator and 12-bit full-duplex shift register for one ADC frame.
// A start pulse loads the config word; the frame then runs 24 SCK
// half-periods. SDI updates on the edge that lowers SCK, SDO is captured
// on the edge that raises SCK. o_done is high in the last frame cycle.
module mda_adc_shifter
  import mda_adc_pkg::*;
#(
  parameter int SCK_HALF = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [CFG_W-1:0]    i_cfg,
  input  logic                i_sdo,
  output logic                o_done,
  output logic                o_sck,
  output logic                o_sdi,
  output logic [RESULT_W-1:0] o_data
);

  localparam int HALVES = 2 * RESULT_W;
  localparam int HCW    = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  logic                r_active;
  logic                r_sck;
  logic [HCW-1:0]      r_half_cnt;
  logic [4:0]          r_half_idx;
  logic [RESULT_W-1:0] r_tx;
  logic [RESULT_W-1:0] r_rx;

  logic w_half_end;
  logic w_last;

  assign w_half_end = (r_half_cnt == HCW'(SCK_HALF - 1));
  assign w_last     = r_active && w_half_end && (r_half_idx == 5'(HALVES - 1));

  // Half-period timing, SCK toggling and both shift directions.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active   <= 1'b0;
      r_sck      <= 1'b0;
      r_half_cnt <= '0;
      r_half_idx <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
    end else if (i_start) begin
      r_active   <= 1'b1;
      r_sck      <= 1'b0;
      r_half_cnt <= '0;
      r_half_idx <= '0;
      r_tx       <= {i_cfg, {(RESULT_W - CFG_W){1'b0}}};
    end else if (r_active) begin
      if (!w_half_end) begin
        r_half_cnt <= r_half_cnt + 1'b1;
      end else begin
        r_half_cnt <= '0;
        if (w_last) begin
          r_active <= 1'b0;
          r_sck    <= 1'b0;
          r_tx     <= '0;
        end else begin
          r_half_idx <= r_half_idx + 1'b1;
          r_sck      <= ~r_sck;
          if (!r_sck) r_rx <= {r_rx[RESULT_W-2:0], i_sdo};
          else        r_tx <= {r_tx[RESULT_W-2:0], 1'b0};
        end
      end
    end
  end

  assign o_done = w_last;
  assign o_sck  = r_sck;
  assign o_sdi  = r_tx[RESULT_W-1];
  assign o_data = r_rx;

endmodule

// File: rtl/mda_adc_sequencer.sv
// LTC2308-style ADC scan sequencer: CONVST pulse, conversion wait, SPI
// frame, acquisition gap. Scans enabled channels in ascending order; the
// word sent in one frame selects the next frame's conversion, so results
// are tagged with the channel configured one frame earlier.
// Optional feature: define MDA_ADC_SWEEP_CNT_EN to add sweep_count[15:0].
module mda_adc_sequencer
  import mda_adc_pkg::*;
#(
  parameter int SCK_HALF    = 2,
  parameter int CONV_CYCLES = 64,
  parameter int ACQ_CYCLES  = 10
) (
  input  logic                spi_clk,
  input  logic                spi_reset,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic [RESULT_W-1:0] result_data,
  output logic [CH_W-1:0]     result_ch,
  output logic                result_valid,
  output logic                sweep_done,
  output logic                busy,
  output logic                ADC_CONVST,
  output logic                ADC_SCK,
  output logic                ADC_SDI,
  input  logic                ADC_SDO
`ifdef MDA_ADC_SWEEP_CNT_EN
  ,
  output logic [15:0]         sweep_count
`endif
);

  state_e              r_state;
  state_e              w_next_state;
  logic [15:0]         r_cnt;
  logic [NUM_CH-1:0]   r_mask;
  logic [CH_W-1:0]     r_cur_ch;
  logic [CH_W-1:0]     r_prev_ch;
  logic                r_prime;
  logic [RESULT_W-1:0] r_result_data;
  logic [CH_W-1:0]     r_result_ch;
  logic                r_result_valid;
  logic                r_sweep_done;

  logic                w_run;
  logic                w_start;
  logic                w_idle_exit;
  logic                w_latch_mask;
  logic                w_frame_end;
  logic                w_advance;
  logic                w_convst;
  logic                w_shift_done;
  logic [RESULT_W-1:0] w_shift_data;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (mask[i]) lowest_set = CH_W'(i);
  endfunction

  function automatic logic [CH_W-1:0] highest_set(input logic [NUM_CH-1:0] mask);
    highest_set = '0;
    for (int i = 0; i < NUM_CH; i++) if (mask[i]) highest_set = CH_W'(i);
  endfunction

  // Next set bit above cur, wrapping; returns cur if it is the only one.
  function automatic logic [CH_W-1:0] next_set(input logic [NUM_CH-1:0] mask,
                                               input logic [CH_W-1:0]   cur);
    logic [CH_W-1:0] idx;
    logic            found;
    next_set = cur;
    found    = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = cur + CH_W'(i);
      if (!found && mask[idx]) begin
        next_set = idx;
        found    = 1'b1;
      end
    end
  endfunction

  // FSM state register and per-state cycle counter.
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (w_next_state != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  // Next-state decode and frame control strobes.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_run        = enable && (ch_mask != '0);
    w_start      = 1'b0;
    w_idle_exit  = 1'b0;
    w_latch_mask = 1'b0;
    w_frame_end  = 1'b0;
    w_advance    = 1'b0;
    w_convst     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_run) begin
          w_next_state = S_CONVST;
          w_idle_exit  = 1'b1;
          w_latch_mask = 1'b1;
        end
      end
      S_CONVST: begin
        w_convst = 1'b1;
        if (r_cnt == 16'(CONVST_CYCLES - 1)) w_next_state = S_CONV;
      end
      S_CONV: begin
        if (r_cnt == 16'(CONV_CYCLES - 1)) begin
          w_next_state = S_SHIFT;
          w_start      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_shift_done) begin
          w_next_state = S_DONE;
          w_frame_end  = 1'b1;
        end
      end
      S_DONE: begin
        w_next_state = S_ACQ;
        w_advance    = 1'b1;
      end
      S_ACQ: begin
        if (r_cnt == 16'(ACQ_CYCLES - 1)) begin
          if (w_run) begin
            w_next_state = S_CONVST;
            w_latch_mask = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Mask latch, channel pipeline, priming and result strobes.
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      r_mask         <= '0;
      r_cur_ch       <= '0;
      r_prev_ch      <= '0;
      r_prime        <= 1'b1;
      r_result_data  <= '0;
      r_result_ch    <= '0;
      r_result_valid <= 1'b0;
      r_sweep_done   <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      r_sweep_done   <= 1'b0;
      if (w_latch_mask) r_mask <= ch_mask;
      if (w_idle_exit) begin
        r_cur_ch <= lowest_set(ch_mask);
        r_prime  <= 1'b1;
      end
      if (w_frame_end && !r_prime) begin
        r_result_valid <= 1'b1;
        r_result_data  <= w_shift_data;
        r_result_ch    <= r_prev_ch;
        r_sweep_done   <= (r_prev_ch == highest_set(r_mask));
      end
      if (w_advance) begin
        r_prime   <= 1'b0;
        r_prev_ch <= r_cur_ch;
        r_cur_ch  <= next_set(r_mask, r_cur_ch);
      end
    end
  end

  mda_adc_shifter #(
    .SCK_HALF (SCK_HALF)
  ) u_shifter (
    .i_clk   (spi_clk),
    .i_rst   (spi_reset),
    .i_start (w_start),
    .i_cfg   (cfg_word(r_cur_ch)),
    .i_sdo   (ADC_SDO),
    .o_done  (w_shift_done),
    .o_sck   (ADC_SCK),
    .o_sdi   (ADC_SDI),
    .o_data  (w_shift_data)
  );

  assign ADC_CONVST   = w_convst;
  assign busy         = (r_state != S_IDLE);
  assign result_data  = r_result_data;
  assign result_ch    = r_result_ch;
  assign result_valid = r_result_valid;
  assign sweep_done   = r_sweep_done;

`ifdef MDA_ADC_SWEEP_CNT_EN
  logic [15:0] r_sweep_count;

  // Completed-sweep counter, wraps naturally at 16 bits.
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset)         r_sweep_count <= '0;
    else if (r_sweep_done) r_sweep_count <= r_sweep_count + 1'b1;
  end

  assign sweep_count = r_sweep_count;
`endif

endmodule

// File: tb/tb_mda_adc_sequencer.sv
// Self-checking bench for mda_adc_sequencer with a behavioural LTC2308
// model on the SPI pins. Expected results come from the scan order of the
// mask (ascending list, wrapping) and the model's per-channel values.
module tb_mda_adc_sequencer;

  logic        spi_clk = 1'b0;
  logic        spi_reset;
  logic        enable;
  logic [7:0]  ch_mask;
  logic [11:0] result_data;
  logic [2:0]  result_ch;
  logic        result_valid;
  logic        sweep_done;
  logic        busy;
  logic        ADC_CONVST;
  logic        ADC_SCK;
  logic        ADC_SDI;
  logic        adc_sdo = 1'b0;
`ifdef MDA_ADC_SWEEP_CNT_EN
  logic [15:0] sweep_count;
`endif

  mda_adc_sequencer dut (
    .spi_clk      (spi_clk),
    .spi_reset    (spi_reset),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .result_data  (result_data),
    .result_ch    (result_ch),
    .result_valid (result_valid),
    .sweep_done   (sweep_done),
    .busy         (busy),
    .ADC_CONVST   (ADC_CONVST),
    .ADC_SCK      (ADC_SCK),
    .ADC_SDI      (ADC_SDI),
    .ADC_SDO      (adc_sdo)
`ifdef MDA_ADC_SWEEP_CNT_EN
    ,
    .sweep_count  (sweep_count)
`endif
  );

  always #5 spi_clk = ~spi_clk;

  int unsigned cyc = 0;
  always @(posedge spi_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected LTC2308 config word for a channel.
  function automatic logic [5:0] exp_cfg(input int ch);
    logic [2:0] c;
    c = 3'(ch);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

  // ---------------- behavioural LTC2308 ----------------
  logic [11:0] adc_mem [8];
  logic [2:0]  adc_cfg_ch = 3'd0;
  logic [11:0] adc_word   = '0;
  int          adc_bit    = 0;
  int          adc_nbits  = 6;
  logic [5:0]  adc_rx     = '0;
  logic [5:0]  words_q [$];

  always @(posedge ADC_CONVST or posedge ADC_SCK or negedge ADC_SCK) begin
    if (ADC_SCK) begin
      if (adc_nbits < 6) begin
        adc_rx = {adc_rx[4:0], ADC_SDI};
        adc_nbits++;
        if (adc_nbits == 6) begin
          words_q.push_back(adc_rx);
          adc_cfg_ch = {adc_rx[3], adc_rx[2], adc_rx[4]};
        end
      end
    end else if (ADC_CONVST) begin
      adc_word  = adc_mem[adc_cfg_ch];
      adc_bit   = 11;
      adc_sdo   = adc_word[11];
      adc_nbits = 0;
    end else if (adc_bit > 0) begin
      adc_bit--;
      adc_sdo = adc_word[adc_bit];
    end
  end

  // ---------------- output monitor ----------------
  typedef struct {
    int unsigned cyc;
    logic [2:0]  ch;
    logic [11:0] data;
    logic        sweep;
  } strobe_t;

  strobe_t     strobes [$];
  int unsigned convst_q [$];
  int          orphan_sweep = 0;
  logic        prev_convst  = 1'b0;
  strobe_t     mon_s;

  always @(negedge spi_clk) begin
    if (result_valid) begin
      mon_s.cyc   = cyc;
      mon_s.ch    = result_ch;
      mon_s.data  = result_data;
      mon_s.sweep = sweep_done;
      strobes.push_back(mon_s);
    end
    if (sweep_done && !result_valid) orphan_sweep++;
    if (ADC_CONVST && !prev_convst) convst_q.push_back(cyc);
    prev_convst = ADC_CONVST;
  end

  // ---------------- helpers ----------------
  task automatic randomize_mem();
    for (int i = 0; i < 8; i++) adc_mem[i] = 12'($urandom);
  endtask

  task automatic clear_logs();
    strobes.delete();
    words_q.delete();
    convst_q.delete();
  endtask

  task automatic wait_idle(input int budget, output int unsigned fall_cyc);
    for (int t = 0; t < budget && busy; t++) @(negedge spi_clk);
    fall_cyc = cyc;
    check("busy_fall", busy, 1'b0);
  endtask

  task automatic wait_strobes(input int n, input int budget);
    for (int t = 0; t < budget && strobes.size() < n; t++) @(negedge spi_clk);
  endtask

  task automatic wait_sck_high(input int budget);
    for (int t = 0; t < budget && !ADC_SCK; t++) @(negedge spi_clk);
    check("sck_seen", ADC_SCK, 1'b1);
  endtask

  // Continuous scan: checks latency, order, data, sweep, period, SDI words.
  task automatic run_scan(input logic [7:0] mask, input int want);
    int          list [$];
    int          n;
    int          ch;
    int unsigned e;
    int unsigned fall;
    for (int i = 0; i < 8; i++) if (mask[i]) list.push_back(i);
    n = list.size();
    @(negedge spi_clk);
    clear_logs();
    ch_mask = mask;
    enable  = 1'b1;
    e       = cyc;
    wait_strobes(want, (want + 2) * 125);
    enable = 1'b0;
    check("scan_strobes", 32'(strobes.size() >= want), 1);
    wait_idle(300, fall);
    if (strobes.size() > 0) check("first_latency", strobes[0].cyc - e, 240);
    foreach (strobes[i]) begin
      ch = list[i % n];
      check("res_ch", strobes[i].ch, ch);
      check("res_data", strobes[i].data, adc_mem[ch]);
      check("sweep", strobes[i].sweep, ch == list[n-1]);
      if (i > 0) check("period", strobes[i].cyc - strobes[i-1].cyc, 125);
    end
    check("frames", words_q.size(), strobes.size() + 1);
    foreach (words_q[k]) check("sdi_word", words_q[k], exp_cfg(list[k % n]));
    check("convst_cnt", convst_q.size(), words_q.size());
  endtask

  // enable falls during SHIFT of frame 3: that frame still reports, then IDLE.
  task automatic drop_in_shift(input logic [7:0] mask);
    int          list [$];
    int          n;
    int unsigned fall;
    for (int i = 0; i < 8; i++) if (mask[i]) list.push_back(i);
    n = list.size();
    randomize_mem();
    @(negedge spi_clk);
    clear_logs();
    ch_mask = mask;
    enable  = 1'b1;
    wait_strobes(1, 400);
    wait_sck_high(200);
    enable = 1'b0;
    wait_strobes(2, 200);
    wait_idle(200, fall);
    check("drop_strobes", strobes.size(), 2);
    if (strobes.size() >= 2) begin
      check("drop_ch", strobes[1].ch, list[1 % n]);
      check("drop_data", strobes[1].data, adc_mem[list[1 % n]]);
      check("drop_period", strobes[1].cyc - strobes[0].cyc, 125);
      check("drop_busy_lag", fall - strobes[1].cyc, 11);
    end
    check("drop_convst_cnt", convst_q.size(), 3);
  endtask

  // Reset in the middle of SHIFT; scan restarts with a priming frame.
  task automatic reset_in_shift(input logic [7:0] mask);
    int          list [$];
    int unsigned e;
    int unsigned fall;
    for (int i = 0; i < 8; i++) if (mask[i]) list.push_back(i);
    randomize_mem();
    @(negedge spi_clk);
    clear_logs();
    ch_mask = mask;
    enable  = 1'b1;
    wait_sck_high(300);
    spi_reset = 1'b1;
    #1;
    check("rst_sck", ADC_SCK, 1'b0);
    check("rst_sdi", ADC_SDI, 1'b0);
    check("rst_convst", ADC_CONVST, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge spi_clk);
    spi_reset = 1'b0;
    clear_logs();
    e = cyc;
    wait_strobes(1, 400);
    enable = 1'b0;
    check("rst_strobe_seen", strobes.size(), 1);
    if (strobes.size() > 0) begin
      check("rst_prime_latency", strobes[0].cyc - e, 240);
      check("rst_ch", strobes[0].ch, list[0]);
      check("rst_data", strobes[0].data, adc_mem[list[0]]);
    end
    wait_idle(300, fall);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    spi_reset = 1'b1;
    enable    = 1'b0;
    ch_mask   = 8'h00;
    randomize_mem();
    repeat (3) @(negedge spi_clk);
    check("reset_data", result_data, 12'h000);
    check("reset_ch", result_ch, 3'd0);
    check("reset_valid", result_valid, 1'b0);
    check("reset_sweep", sweep_done, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_convst", ADC_CONVST, 1'b0);
    check("reset_sck", ADC_SCK, 1'b0);
    check("reset_sdi", ADC_SDI, 1'b0);
`ifdef MDA_ADC_SWEEP_CNT_EN
    check("reset_sweep_count", sweep_count, 16'h0000);
`endif
    spi_reset = 1'b0;
    repeat (20) @(negedge spi_clk);
    check("idle_busy", busy, 1'b0);
    check("idle_no_convst", convst_q.size(), 0);

    // enable with an empty mask must not start.
    enable  = 1'b1;
    ch_mask = 8'h00;
    repeat (30) @(negedge spi_clk);
    check("mask0_busy", busy, 1'b0);
    check("mask0_no_convst", convst_q.size(), 0);
    enable = 1'b0;

    // Two-channel directed scan.
    randomize_mem();
    adc_mem[0] = 12'hABC;
    adc_mem[2] = 12'h123;
    run_scan(8'h05, 4);

    // Single channel: sweep on every result.
    randomize_mem();
    run_scan(8'h80, 3);

`ifdef MDA_ADC_SWEEP_CNT_EN
    begin
      int unsigned fall;
      @(negedge spi_clk);
      clear_logs();
      ch_mask = 8'h80;
      enable  = 1'b1;
      force dut.r_sweep_count = 16'hFFFF;
      #1;
      release dut.r_sweep_count;
      wait_strobes(1, 400);
      enable = 1'b0;
      repeat (2) @(negedge spi_clk);
      check("sweep_count_wrap", sweep_count, 16'h0000);
      wait_idle(300, fall);
    end
`endif

    // Random masks.
    for (int r = 0; r < 4; r++) begin
      logic [7:0] m;
      int         pc;
      m  = 8'($urandom_range(1, 255));
      pc = $countones(m);
      randomize_mem();
      run_scan(m, (pc + 2 > 10) ? 10 : pc + 2);
    end

    drop_in_shift(8'($urandom_range(1, 255)));
    reset_in_shift(8'($urandom_range(1, 255)));

    check("orphan_sweep", orphan_sweep, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
